// File: rtl/arbitro_alu.sv
`default_nettype none
// ============================================================================
//  Module   : arbitro_alu
//  Purpose  : Two-requester round-robin arbiter and sequencer in front of the
//             shared 8-bit ALU. Accepts one (A, B, op) request, drives it onto
//             the ALU for one execute cycle, captures the result and zero flag,
//             and holds the response until the owning requester acknowledges.
//  Ports    : clk, reset                  - clock, synchronous active-high reset
//             reqX_valid/A/B/op, reqX_ready - request handshake, X = 0, 1
//             respX_valid, respX_ack      - response handshake, X = 0, 1
//             resp_resultado, resp_zero   - registered ALU result and flag
//             alu_A, alu_B, alu_op        - ALU operand/opcode drive
//             alu_resultado, alu_zero     - ALU outputs
//  Revision : 1.0 - initial release
// ============================================================================
module arbitro_alu #(
   parameter int LARGURA = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req0_valid,
   input  logic [LARGURA-1:0] req0_A,
   input  logic [LARGURA-1:0] req0_B,
   input  logic [1:0]         req0_op,
   output logic               req0_ready,
   input  logic               req1_valid,
   input  logic [LARGURA-1:0] req1_A,
   input  logic [LARGURA-1:0] req1_B,
   input  logic [1:0]         req1_op,
   output logic               req1_ready,
   output logic               resp0_valid,
   input  logic               resp0_ack,
   output logic               resp1_valid,
   input  logic               resp1_ack,
   output logic [LARGURA-1:0] resp_resultado,
   output logic               resp_zero,
   output logic [LARGURA-1:0] alu_A,
   output logic [LARGURA-1:0] alu_B,
   output logic [1:0]         alu_op,
   input  logic [LARGURA-1:0] alu_resultado,
   input  logic               alu_zero
);

   typedef enum logic [1:0] {
      OCIOSO   = 2'd0,
      EXECUTA  = 2'd1,
      RESPOSTA = 2'd2
   } estado_t;

   estado_t            estado;
   estado_t            prox_estado;
   logic [LARGURA-1:0] reg_a;
   logic [LARGURA-1:0] reg_b;
   logic [1:0]         reg_op;
   logic               dono;        // id of the requester owning the current operation
   logic               ultimo;      // id of the most recent grant
   logic               concede;     // a grant happens this cycle
   logic               id_concede;  // which requester is granted
   logic               ack_dono;    // ack from the owning requester only

   // Next-state and grant decode
   always_comb begin
      prox_estado = estado;
      concede     = 1'b0;
      id_concede  = 1'b0;
      ack_dono    = dono ? resp1_ack : resp0_ack;
      case (estado)
         OCIOSO: begin
            // Masked during reset so a requester never sees an accept that
            // the reset is about to discard.
            if ((req0_valid || req1_valid) && !reset) begin
               concede     = 1'b1;
               // Tie goes to the requester that was not served last.
               id_concede  = (req0_valid && req1_valid) ? ~ultimo : req1_valid;
               prox_estado = EXECUTA;
            end
         end
         EXECUTA: begin
            prox_estado = RESPOSTA;
         end
         RESPOSTA: begin
            if (ack_dono) begin
               prox_estado = OCIOSO;
            end
         end
         default: begin
            prox_estado = OCIOSO;
         end
      endcase
   end

   // State, operand and response registers
   always_ff @(posedge clk) begin
      if (reset) begin
         estado         <= OCIOSO;
         reg_a          <= '0;
         reg_b          <= '0;
         reg_op         <= 2'b00;
         dono           <= 1'b0;
         ultimo         <= 1'b1;
         resp_resultado <= '0;
         resp_zero      <= 1'b0;
      end else begin
         estado <= prox_estado;
         if (concede) begin
            reg_a  <= id_concede ? req1_A  : req0_A;
            reg_b  <= id_concede ? req1_B  : req0_B;
            reg_op <= id_concede ? req1_op : req0_op;
            dono   <= id_concede;
            ultimo <= id_concede;
         end
         if (estado == EXECUTA) begin
            resp_resultado <= alu_resultado;
            resp_zero      <= alu_zero;
         end
      end
   end

   assign req0_ready  = concede && !id_concede;
   assign req1_ready  = concede &&  id_concede;
   assign resp0_valid = (estado == RESPOSTA) && !dono;
   assign resp1_valid = (estado == RESPOSTA) &&  dono;

   // Operand registers hold their value between operations.
   assign alu_A  = reg_a;
   assign alu_B  = reg_b;
   assign alu_op = reg_op;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_alu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_arbitro_alu
//  Purpose  : Self-checking bench for arbitro_alu. A behavioural ALU sits on
//             the alu_* ports; accepted requests push expected responses to a
//             scoreboard that is popped when a response appears.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_arbitro_alu;

   localparam int LARGURA = 8;

   logic               clk = 1'b0;
   logic               reset;
   logic               req0_valid, req1_valid;
   logic [LARGURA-1:0] req0_A, req0_B, req1_A, req1_B;
   logic [1:0]         req0_op, req1_op;
   logic               req0_ready, req1_ready;
   logic               resp0_valid, resp1_valid;
   logic               resp0_ack, resp1_ack;
   logic [LARGURA-1:0] resp_resultado;
   logic               resp_zero;
   logic [LARGURA-1:0] alu_A, alu_B;
   logic [1:0]         alu_op;
   logic [LARGURA-1:0] alu_resultado;
   logic               alu_zero;

   arbitro_alu #(.LARGURA(LARGURA)) dut (
      .clk            (clk),
      .reset          (reset),
      .req0_valid     (req0_valid),
      .req0_A         (req0_A),
      .req0_B         (req0_B),
      .req0_op        (req0_op),
      .req0_ready     (req0_ready),
      .req1_valid     (req1_valid),
      .req1_A         (req1_A),
      .req1_B         (req1_B),
      .req1_op        (req1_op),
      .req1_ready     (req1_ready),
      .resp0_valid    (resp0_valid),
      .resp0_ack      (resp0_ack),
      .resp1_valid    (resp1_valid),
      .resp1_ack      (resp1_ack),
      .resp_resultado (resp_resultado),
      .resp_zero      (resp_zero),
      .alu_A          (alu_A),
      .alu_B          (alu_B),
      .alu_op         (alu_op),
      .alu_resultado  (alu_resultado),
      .alu_zero       (alu_zero)
   );

   always #5 clk = ~clk;

   // ALU model: zero is the compare flag, raised only by a subtract giving 0.
   function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic [1:0] op);
      logic [7:0] r;
      case (op)
         2'b00:   r = a + b;
         2'b01:   r = a - b;
         2'b10:   r = a & b;
         default: r = a | b;
      endcase
      return {(op == 2'b01) && (r == 8'd0), r};
   endfunction

   assign {alu_zero, alu_resultado} = alu_model(alu_A, alu_B, alu_op);

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   typedef struct {
      logic       id;
      logic [7:0] res;
      logic       z;
      int         cyc;
   } exp_t;

   exp_t sb[$];
   int   grants[$];
   int   cyc     = 0;
   logic prev_v0 = 1'b0;
   logic prev_v1 = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) sb.delete();   // an aborted operation must never respond
   end

   // Monitor: push on accept, pop and compare on a new response.
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (req0_ready || req1_ready) begin
            check("ready_onehot", {31'd0, req0_ready & req1_ready}, 32'd0);
            e.id  = req1_ready;
            {e.z, e.res} = req1_ready ? alu_model(req1_A, req1_B, req1_op)
                                      : alu_model(req0_A, req0_B, req0_op);
            e.cyc = cyc;
            sb.push_back(e);
            grants.push_back(int'(req1_ready));
         end
         if ((resp0_valid && !prev_v0) || (resp1_valid && !prev_v1)) begin
            check("resp_expected", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
               e = sb.pop_front();
               check("resp_id",        {31'd0, resp1_valid}, {31'd0, e.id});
               check("resp_one_owner", {31'd0, resp0_valid & resp1_valid}, 32'd0);
               check("resp_result",    {24'd0, resp_resultado}, {24'd0, e.res});
               check("resp_zero",      {31'd0, resp_zero}, {31'd0, e.z});
               check("resp_latency",   cyc - e.cyc, 32'd2);
            end
         end
      end
      prev_v0 = resp0_valid;
      prev_v1 = resp1_valid;
   end

   task automatic request(input logic id, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] op);
      int t;
      @(posedge clk); #1;
      if (!id) begin
         req0_valid = 1'b1; req0_A = a; req0_B = b; req0_op = op;
      end else begin
         req1_valid = 1'b1; req1_A = a; req1_B = b; req1_op = op;
      end
      t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(id ? req1_ready : req0_ready) && t < 50);
      check("accept_seen", {31'd0, id ? req1_ready : req0_ready}, 32'd1);
      @(posedge clk); #1;
      if (!id) req0_valid = 1'b0; else req1_valid = 1'b0;
      @(negedge clk);
      check("alu_A_drive",  {24'd0, alu_A}, {24'd0, a});
      check("alu_B_drive",  {24'd0, alu_B}, {24'd0, b});
      check("alu_op_drive", {30'd0, alu_op}, {30'd0, op});
   endtask

   task automatic wait_resp(input logic id);
      int t;
      t = 0;
      while (!(id ? resp1_valid : resp0_valid) && t < 50) begin
         @(negedge clk);
         t++;
      end
      check("resp_seen", {31'd0, id ? resp1_valid : resp0_valid}, 32'd1);
   endtask

   task automatic check_reset_outputs();
      check("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
      check("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
      check("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);
      check("rst_resp1_valid", {31'd0, resp1_valid}, 32'd0);
      check("rst_resultado", {24'd0, resp_resultado}, 32'd0);
      check("rst_zero", {31'd0, resp_zero}, 32'd0);
      check("rst_alu_A", {24'd0, alu_A}, 32'd0);
      check("rst_alu_B", {24'd0, alu_B}, 32'd0);
      check("rst_alu_op", {30'd0, alu_op}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int t;
      reset = 1'b1;
      req0_valid = 1'b0; req0_A = '0; req0_B = '0; req0_op = 2'b00;
      req1_valid = 1'b0; req1_A = '0; req1_B = '0; req1_op = 2'b00;
      resp0_ack = 1'b1; resp1_ack = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_reset_outputs();

      // Basic add, ack held high
      request(1'b0, 8'd100, 8'd27, 2'b00);
      wait_resp(1'b0);

      // Compare from requester 1: equal and unequal operands
      request(1'b1, 8'h5A, 8'h5A, 2'b01);
      wait_resp(1'b1);
      request(1'b1, 8'd3, 8'd5, 2'b01);
      wait_resp(1'b1);

      // Both continuously valid: grants must alternate 0,1,0,1
      base = grants.size();
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_A = 8'hF0; req0_B = 8'h3C; req0_op = 2'b10;
      req1_valid = 1'b1; req1_A = 8'h0F; req1_B = 8'h30; req1_op = 2'b11;
      t = 0;
      while (grants.size() - base < 4 && t < 60) begin
         @(posedge clk); #1;
         t++;
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      check("tie_grant_count", grants.size() - base, 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (base + i < grants.size())
            check("tie_grant_order", grants[base + i], i % 2);
      end
      repeat (4) @(negedge clk);

      // Delayed ack: response held, other requester waits, foreign ack ignored
      resp0_ack = 1'b0;
      resp1_ack = 1'b0;
      request(1'b0, 8'd10, 8'd20, 2'b00);
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_A = 8'h44; req1_B = 8'h04; req1_op = 2'b01;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("hold_resp0_valid", {31'd0, resp0_valid}, 32'd1);
         check("hold_resultado", {24'd0, resp_resultado}, 32'd30);
         check("hold_req1_ready", {31'd0, req1_ready}, 32'd0);
         @(posedge clk); #1;
         resp1_ack = ~resp1_ack;
      end
      resp0_ack = 1'b1;
      resp1_ack = 1'b1;
      @(negedge clk);
      check("ack_cycle_req1_ready", {31'd0, req1_ready}, 32'd0);
      @(negedge clk);
      check("after_ack_resp0_valid", {31'd0, resp0_valid}, 32'd0);
      check("after_ack_req1_ready", {31'd0, req1_ready}, 32'd1);
      @(posedge clk); #1;
      req1_valid = 1'b0;
      wait_resp(1'b1);

      // Wrap-around add
      request(1'b0, 8'hFF, 8'h01, 2'b00);
      wait_resp(1'b0);

      // Reset during EXECUTA
      request(1'b0, 8'd7, 8'd9, 2'b00);
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check_reset_outputs();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("abort_no_resp0", {31'd0, resp0_valid}, 32'd0);
      end

      // Reset during RESPOSTA, then a tie must go to requester 0
      resp0_ack = 1'b0;
      request(1'b0, 8'd7, 8'd9, 2'b00);
      wait_resp(1'b0);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      resp0_ack = 1'b1;
      @(negedge clk);
      check_reset_outputs();
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_A = 8'd1; req0_B = 8'd2; req0_op = 2'b00;
      req1_valid = 1'b1; req1_A = 8'd4; req1_B = 8'd4; req1_op = 2'b01;
      @(negedge clk);
      check("post_reset_tie_req0", {31'd0, req0_ready}, 32'd1);
      check("post_reset_tie_req1", {31'd0, req1_ready}, 32'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      repeat (6) @(negedge clk);
      check("sb_drained", sb.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/arbitro_alu.md
# arbitro_alu

Two-requester round-robin arbiter and sequencer for the shared 8-bit ALU. Each requester submits an (A, B, op) triple with a valid/ready handshake. The block registers the winning operands and drives them onto the ALU for one execute cycle. It then captures `resultado_ALU` and `zero` and holds the response until the owning requester acknowledges it. It sits between the datapath (requester 0) and the branch/compare unit (requester 1) and the single ALU instance.

## Interface
Parameters:
- `LARGURA`, 8, operand/result width; must match the ALU.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req0_valid`, `req1_valid`  in  1  requester has an operation pending.
- `req0_A`, `req1_A`  in  LARGURA  operand A.
- `req0_B`, `req1_B`  in  LARGURA  operand B.
- `req0_op`, `req1_op`  in  2  ALU opcode: 00 add, 01 sub/compare, 10 and, 11 or.
- `req0_ready`, `req1_ready`  out  1  one-cycle accept pulse; the operands are captured in that cycle.
- `resp0_valid`, `resp1_valid`  out  1  response available for that requester.
- `resp0_ack`, `resp1_ack`  in  1  requester consumes the response.
- `resp_resultado`  out  LARGURA  registered ALU result; meaningful only while some `respX_valid` = 1.
- `resp_zero`  out  1  registered ALU `zero` flag; meaningful only while some `respX_valid` = 1.
- `alu_A`, `alu_B`  out  LARGURA  ALU operand inputs.
- `alu_op`  out  2  drives the ALU `Controle_ALUop` input.
- `alu_resultado`  in  LARGURA  ALU `resultado_ALU` output.
- `alu_zero`  in  1  ALU `zero` output.

## Operation
FSM states: OCIOSO, EXECUTA, RESPOSTA.

OCIOSO:
- If any `reqX_valid` = 1, grant one requester.
- Assert that requester's `reqX_ready` combinationally in this cycle.
- Latch A, B, op and the grant id into registers.
- Next state: EXECUTA.
- If no request is valid, stay in OCIOSO.

EXECUTA:
- `alu_A`, `alu_B`, `alu_op` are driven from the latched registers.
- On the clock edge, capture `alu_resultado` into `resp_resultado` and `alu_zero` into `resp_zero`.
- Next state: RESPOSTA.

RESPOSTA:
- `respX_valid` = 1 for the granted requester only.
- Stay until that requester's `respX_ack` = 1, then go to OCIOSO.
- The ack of the non-granted requester is ignored.

ALU drive:
- `alu_A`, `alu_B`, `alu_op` always come from the operand registers.
- The registers are zero after reset, so the idle ALU drive is A = 0, B = 0, op = 00.
- The registers are not cleared after an operation; they hold the last operands.

Round-robin:
- A 1-bit register `ultimo` holds the id of the last grant.
- When both requesters are valid, grant the one ≠ `ultimo`.
- When one requester is valid, grant it regardless of `ultimo`.
- `ultimo` updates only on a grant.
- Reset value is `ultimo` = 1, so requester 0 wins the first tie.

Requester rules:
- A requester must hold valid and its operands stable until it sees ready.
- The block never accepts a new request while in EXECUTA or RESPOSTA; both `ready` outputs are 0 there.
- A requester may raise a new valid while waiting for its own response. It is accepted only after the return to OCIOSO.

Reset:
- Values: state = OCIOSO; all `ready` and `resp_valid` = 0; `resp_resultado` = 0; `resp_zero` = 0; operand registers = 0; `alu_op` = 00; `ultimo` = 1.
- Reset asserted in EXECUTA or RESPOSTA aborts the operation. No response is ever delivered for it.

Arithmetic: performed entirely by the ALU. Results wrap modulo 2^LARGURA and there is no carry output.

## Timing
- Request accepted in cycle N (`ready` = 1 in N).
- Cycle N+1: EXECUTA; the ALU sees the new operands.
- Cycle N+2: `resp_valid` = 1, `resp_resultado` and `resp_zero` valid.
- Ack in cycle M ≥ N+2 deassigns `resp_valid` at M+1, and the state is OCIOSO at M+1.
- The next accept is possible at M+1.
- Best-case throughput: one operation per 3 cycles (ack held high in N+2).
- Fairness: with both requesters continuously valid, grants strictly alternate.
- Ready is a Mealy output from state OCIOSO plus `valid` and `ultimo`. All other outputs are registered or decoded from state.

## Test plan
1. Reset, then `req0`: A = 8'd100, B = 8'd27, op = 00; ack held 1 → `req0_ready` in cycle N; `resp0_valid` at N+2 with `resp_resultado` = 127, `resp_zero` = 0; `resp1_valid` stays 0.
2. `req1`: A = B = 8'h5A, op = 01 → `resp_resultado` = 0, `resp_zero` = 1. Repeat with A = 3, B = 5 → `resp_resultado` = 8'hFE, `resp_zero` = 0.
3. Both valid continuously for 4 operations (req0: 8'hF0 & 8'h3C; req1: 8'h0F | 8'h30) → grant order 0,1,0,1; results 8'h30 and 8'h3F respectively.
4. Delay the ack 5 cycles while req1 is valid → `resp0_valid` and `resp_resultado` held stable; `req1_ready` stays 0 until the cycle after the ack; `resp1_ack` pulses during the wait are ignored.
5. Wrap-around: A = 8'hFF, B = 8'h01, op = 00 → `resp_resultado` = 0, `resp_zero` = 0.
6. Assert reset in EXECUTA, then in RESPOSTA → next cycle all outputs are at their reset values; no `resp_valid` ever appears for the aborted operation; the next tie grants requester 0.
